// File: rtl/benes_route_ctrl_if.sv
// Handshake bundle between the permutation source, the Benes
// route controller and the switch-control consumer.
interface benes_route_ctrl_if #(
  parameter int N      = 32,
  parameter int AW     = $clog2(N),
  parameter int SW     = N / 2,
  parameter int STAGES = 2 * AW - 1,
  parameter int SGW    = $clog2(STAGES)
);
  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  in_dst;
  logic           ctrl_valid;
  logic           ctrl_ready;
  logic [SGW-1:0] ctrl_stage;
  logic [SW-1:0]  ctrl_bits;
  logic           ctrl_last;

  modport master (
    output in_valid, in_dst, ctrl_ready,
    input  in_ready, ctrl_valid, ctrl_stage,
    input  ctrl_bits, ctrl_last
  );

  modport slave (
    input  in_valid, in_dst, ctrl_ready,
    output in_ready, ctrl_valid, ctrl_stage,
    output ctrl_bits, ctrl_last
  );
endinterface

// File: rtl/benes_route_ctrl.sv
// Looping-algorithm router for an N-port Benes network.
// Stage 0 is the output-side column, stage STAGES-1 the input-side one.
module benes_route_ctrl #(
  parameter int N      = 32,
  parameter int SW     = N / 2,
  parameter int STAGES = 2 * $clog2(N) - 1,
  parameter int AW     = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  benes_route_ctrl_if.slave   bus,
  output logic                busy,
  output logic                err
);
  localparam int LW  = $clog2(AW);
  localparam int TW  = $clog2(SW);
  localparam int SGW = $clog2(STAGES);

  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, ROUTE, NEXT, MID, EMIT
  } state_t;

  state_t state, nstate;

  logic [AW-1:0]  cnt;
  logic [LW-1:0]  layer;
  logic [TW-1:0]  step;
  logic [SGW-1:0] es;
  logic           err_q;
  logic           dup;
  logic           in_loop;
  logic [AW-1:0]  cur_o;

  logic [AW-1:0]  p  [N];
  logic [AW-1:0]  q  [N];
  logic [AW-1:0]  np [N];
  logic [AW-1:0]  nq [N];
  logic [N-1:0]   hit;
  logic [SW-1:0]  asg;
  logic [SW-1:0]  ctl [STAGES];

  logic acc_in, acc_out, bad, last_w;

  assign acc_in  = bus.in_valid & bus.in_ready;
  assign acc_out = bus.ctrl_valid & bus.ctrl_ready;
  assign bad     = dup | ~(&hit);
  assign last_w  = (es == SGW'(STAGES - 1));

  int            hs;
  logic [AW-1:0] base, half, hmask;
  logic [AW-1:0] o_loc, a, ap, d;
  logic [TW-1:0] sg, ig, jg;
  logic          close;

  // One loop step: pick start switch, follow output->input->output
  always_comb begin
    hs    = AW - 1 - int'(layer);
    half  = AW'(1 << hs);
    hmask = half - AW'(1);
    base  = AW'((int'(step) >> hs) << (hs + 1));
    sg    = '0;
    for (int g = SW - 1; g >= 0; g--) begin
      if (!asg[g]) sg = TW'(g);
    end
    o_loc = in_loop ? cur_o : ((AW'(sg) & hmask) << 1);
    a     = q[base | o_loc];
    ap    = a ^ AW'(1);
    d     = p[base | ap];
    ig    = TW'((base >> 1) | (a >> 1));
    jg    = TW'((base >> 1) | (d >> 1));
    close = asg[jg] | (!in_loop && (jg == sg));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state decode
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (acc_in) nstate = LOAD;
      LOAD:  if (acc_in && cnt == AW'(N - 1))
               nstate = CHECK;
      CHECK: nstate = bad ? IDLE : ROUTE;
      ROUTE: if (step == TW'(SW - 1)) nstate = NEXT;
      NEXT:  nstate = (layer == LW'(AW - 2)) ? MID : ROUTE;
      MID:   nstate = EMIT;
      EMIT:  if (acc_out && last_w) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Control counters and loop-tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      layer   <= '0;
      step    <= '0;
      es      <= '0;
      err_q   <= 1'b0;
      dup     <= 1'b0;
      in_loop <= 1'b0;
      cur_o   <= '0;
    end else begin
      unique case (state)
        IDLE: if (acc_in) begin
          cnt   <= AW'(1);
          err_q <= 1'b0;
          dup   <= 1'b0;
        end
        LOAD: if (acc_in) begin
          cnt <= cnt + AW'(1);
          if (hit[bus.in_dst]) dup <= 1'b1;
        end
        CHECK: begin
          err_q   <= bad;
          layer   <= '0;
          step    <= '0;
          in_loop <= 1'b0;
        end
        ROUTE: begin
          step    <= step + TW'(1);
          in_loop <= !close;
          if (!close) cur_o <= d ^ AW'(1);
        end
        NEXT: begin
          layer   <= layer + LW'(1);
          in_loop <= 1'b0;
        end
        EMIT: if (acc_out) begin
          es <= last_w ? '0 : es + SGW'(1);
        end
        default: ;
      endcase
    end
  end

  // Permutation tables, sub-permutations and control words
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: if (acc_in) begin
        p[0]          <= bus.in_dst;
        q[bus.in_dst] <= '0;
        hit           <= N'(1) << bus.in_dst;
      end
      LOAD: if (acc_in) begin
        p[cnt]          <= bus.in_dst;
        q[bus.in_dst]   <= cnt;
        hit[bus.in_dst] <= 1'b1;
      end
      CHECK: asg <= '0;
      ROUTE: begin
        ctl[SGW'(STAGES - 1) - SGW'(layer)][ig] <= a[0];
        if (!in_loop) begin
          asg[sg]             <= 1'b1;
          ctl[SGW'(layer)][sg] <= 1'b0;
        end
        if (!close) begin
          asg[jg]              <= 1'b1;
          ctl[SGW'(layer)][jg] <= ~d[0];
        end
        np[base | (a >> 1)]            <= o_loc >> 1;
        nq[base | (o_loc >> 1)]        <= a >> 1;
        np[base | half | (ap >> 1)]    <= d >> 1;
        nq[base | half | (d >> 1)]     <= ap >> 1;
      end
      NEXT: begin
        p   <= np;
        q   <= nq;
        asg <= '0;
      end
      MID: begin
        for (int s = 0; s < SW; s++) begin
          ctl[AW-1][s] <= (p[2*s] == AW'(1));
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready   = (state == IDLE) || (state == LOAD);
  assign bus.ctrl_valid = (state == EMIT);
  assign bus.ctrl_stage = es;
  assign bus.ctrl_bits  = bus.ctrl_valid ? ctl[es] : '0;
  assign bus.ctrl_last  = bus.ctrl_valid & last_w;
  assign busy           = (state != IDLE);
  assign err            = err_q;
endmodule

// File: tb/tb_benes_route_ctrl.sv
// Directed and randomized checks of benes_route_ctrl against a
// behavioural looping-algorithm model and a network simulation.
module tb_benes_route_ctrl;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int SW = 16;
  localparam int ST = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;

  benes_route_ctrl_if bus ();

  benes_route_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int dv [N];
  int outv [N];
  logic [SW-1:0] mw  [ST];
  logic [SW-1:0] got [ST];
  int lat;
  int bad;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rstchk(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_valid"}, bus.ctrl_valid, 0);
    chk({tag, "_stage"}, bus.ctrl_stage, 0);
    chk({tag, "_bits"}, bus.ctrl_bits, 0);
    chk({tag, "_last"}, bus.ctrl_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic model();
    int p [N];
    int np [N];
    int inv [N];
    bit dn [SW];
    int m, h, o, a, ap, d2;
    for (int k = 0; k < N; k++) p[k] = dv[k];
    for (int s = 0; s < ST; s++) mw[s] = '0;
    for (int l = 0; l < AW - 1; l++) begin
      m = N >> l;
      h = m / 2;
      for (int b = 0; b < N; b += m) begin
        for (int k = 0; k < m; k++) inv[p[b+k]] = k;
        for (int j = 0; j < h; j++) dn[j] = 1'b0;
        for (int j = 0; j < h; j++) begin
          if (!dn[j]) begin
            dn[j] = 1'b1;
            mw[l][b/2+j] = 1'b0;
            o = 2 * j;
            for (int it = 0; it < h; it++) begin
              a = inv[o];
              mw[ST-1-l][b/2+a/2] = (a % 2) != 0;
              np[b+a/2] = o / 2;
              ap = a ^ 1;
              d2 = p[b+ap];
              np[b+h+ap/2] = d2 / 2;
              if (dn[d2/2]) break;
              dn[d2/2] = 1'b1;
              mw[l][b/2+d2/2] = (d2 % 2) == 0;
              o = d2 ^ 1;
            end
          end
        end
      end
      p = np;
    end
    for (int s = 0; s < SW; s++) mw[AW-1][s] = (p[2*s] == 1);
  endtask

  task automatic net_sim();
    int v [N];
    int t [N];
    int m, h, tmp;
    for (int k = 0; k < N; k++) v[k] = k;
    for (int l = 0; l < AW - 1; l++) begin
      m = N >> l;
      h = m / 2;
      for (int g = 0; g < SW; g++) if (got[ST-1-l][g]) begin
        tmp = v[2*g]; v[2*g] = v[2*g+1]; v[2*g+1] = tmp;
      end
      for (int b = 0; b < N; b += m)
        for (int i = 0; i < h; i++) begin
          t[b+i]   = v[b+2*i];
          t[b+h+i] = v[b+2*i+1];
        end
      v = t;
    end
    for (int g = 0; g < SW; g++) if (got[AW-1][g]) begin
      tmp = v[2*g]; v[2*g] = v[2*g+1]; v[2*g+1] = tmp;
    end
    for (int l = AW - 2; l >= 0; l--) begin
      m = N >> l;
      h = m / 2;
      for (int b = 0; b < N; b += m)
        for (int i = 0; i < h; i++) begin
          t[b+2*i]   = v[b+i];
          t[b+2*i+1] = v[b+h+i];
        end
      v = t;
      for (int g = 0; g < SW; g++) if (got[l][g]) begin
        tmp = v[2*g]; v[2*g] = v[2*g+1]; v[2*g+1] = tmp;
      end
    end
    outv = v;
    bad = 0;
    for (int k = 0; k < N; k++) if (outv[dv[k]] != k) bad++;
  endtask

  task automatic load();
    int g;
    for (int k = 0; k < N; k++) begin
      g = 0;
      bus.in_valid = 1'b1;
      bus.in_dst = AW'(dv[k]);
      while (!bus.in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_route(input bit noise);
    lat = 0;
    while (!bus.ctrl_valid && lat < 200) begin
      if (noise) begin
        bus.in_valid = 1'b1;
        bus.in_dst = AW'($urandom_range(0, N - 1));
      end
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("route_latency", lat <= 86, 1);
  endtask

  task automatic collect(input bit rnd);
    int e;
    int g;
    e = 0;
    g = 0;
    while (e < ST && g < 1000) begin
      if (bus.ctrl_valid) begin
        chk("stage", bus.ctrl_stage, e);
        chk("bits", bus.ctrl_bits, mw[e]);
        chk("last", bus.ctrl_last, e == ST - 1);
        got[e] = bus.ctrl_bits;
      end
      bus.ctrl_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.ctrl_valid && bus.ctrl_ready) e++;
      @(negedge clk);
      g++;
    end
    bus.ctrl_ready = 1'b0;
    chk("word_count", e, ST);
    chk("valid_after", bus.ctrl_valid, 0);
    chk("busy_after", busy, 0);
    chk("err_after", err, 0);
  endtask

  task automatic shuffle();
    int j, tmp;
    for (int k = 0; k < N; k++) dv[k] = k;
    for (int k = N - 1; k > 0; k--) begin
      j = $urandom_range(0, k);
      tmp = dv[k]; dv[k] = dv[j]; dv[j] = tmp;
    end
  endtask

  task automatic ident();
    for (int k = 0; k < N; k++) dv[k] = k;
    for (int s = 0; s < ST; s++) mw[s] = '0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_dst = '0;
    bus.ctrl_ready = 1'b0;
    #12;
    rstchk("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    ident();
    load();
    wait_route(1'b0);
    collect(1'b0);

    for (int k = 0; k < N; k++) dv[k] = N - 1 - k;
    model();
    load();
    wait_route(1'b1);
    collect(1'b1);
    net_sim();
    chk("rev_route", bad, 0);
    chk("rev_in0", outv[31], 0);
    chk("rev_in31", outv[0], 31);

    ident();
    dv[0] = 1;
    dv[1] = 0;
    mw[8] = 16'h0001;
    load();
    wait_route(1'b0);
    collect(1'b1);
    chk("swap_st0_sw0", got[0][0], 0);
    net_sim();
    chk("swap_route", bad, 0);

    ident();
    dv[3] = 5;
    dv[7] = 5;
    load();
    for (int i = 0; i < 4; i++) begin
      chk("dup_no_valid", bus.ctrl_valid, 0);
      @(negedge clk);
    end
    chk("dup_err", err, 1);
    chk("dup_idle", busy, 0);
    chk("dup_in_ready", bus.in_ready, 1);
    ident();
    load();
    chk("err_cleared", err, 0);
    wait_route(1'b0);
    collect(1'b0);

    for (int r = 0; r < 200; r++) begin
      shuffle();
      model();
      load();
      wait_route(r[0]);
      collect(1'b1);
      net_sim();
      chk("rand_route", bad, 0);
    end

    shuffle();
    load();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rstchk("rst_route");
    @(negedge clk);
    rst_n = 1'b1;

    shuffle();
    load();
    lat = 0;
    while (!bus.ctrl_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("emit_reached", bus.ctrl_valid, 1);
    bus.ctrl_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.ctrl_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 rstchk("rst_emit");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", bus.ctrl_valid, 0);
    end

    ident();
    load();
    wait_route(1'b0);
    collect(1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
